fixed_p_std_div_pipe: RTL and testbench
=======================================

# fixed_p_std_div_pipe

Multi-cycle, synthesizable unsigned fixed-point divider. It is the inverse operation of the fixed-point multiplier and the replacement for the combinational, unsynthesizable fixed-point divide. It computes `(left * 2^FRACT_WIDTH) / right` with restoring long division, producing one quotient bit per cycle behind a go/done handshake. It sits alongside the other unsigned fixed-point primitives and is driven by the compiler's group control logic.

## Interface
- `WIDTH`, default 32: total operand/result width.
- `INT_WIDTH`, default 8: integer bits. Must satisfy `INT_WIDTH + FRACT_WIDTH == WIDTH`; elaboration `$error` otherwise.
- `FRACT_WIDTH`, default 24: fraction bits.
- `clk`  in  1: the single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `go`  in  1: start request, sampled only in IDLE.
- `left`  in  WIDTH: dividend, unsigned fixed-point.
- `right`  in  WIDTH: divisor, unsigned fixed-point.
- `out_quotient`  out  WIDTH: quotient in the same fixed-point format, truncated toward zero.
- `out_remainder`  out  WIDTH: integer remainder `r`, where `left*2^FRACT_WIDTH = q*right + r` and `r < right`.
- `overflow`  out  1: the quotient did not fit in WIDTH bits.
- `div_by_zero`  out  1: `right` was 0.
- `done`  out  1: one-cycle pulse; results are valid from this cycle onward.

## Operation
- Let `N = WIDTH + FRACT_WIDTH`.
  - Dividend register: N bits, loaded with `{left, FRACT_WIDTH'b0}`.
  - Partial remainder: WIDTH+1 bits.
  - Quotient register: N bits.
  - Iteration counter: `$clog2(N+1)` bits.
- States:
  - **IDLE**
    - `go=1` and `right!=0`: latch the operands, clear the remainder and counter, go to RUN.
    - `go=1` and `right==0`: go to DONE with the divide-by-zero result.
    - `go=0`: stay in IDLE.
  - **RUN** (one step per cycle)
    - Shift the dividend MSB into the remainder.
    - If `remainder >= divisor`: subtract it and shift in quotient bit 1; otherwise shift in 0.
    - Increment the counter. After the Nth step, go to DONE.
  - **DONE**: load the output registers, pulse `done`, return to IDLE.
- Results in the DONE cycle:
  - `out_quotient = q[WIDTH-1:0]`. Upper bits are discarded; the quotient wraps, consistent with fixed-point add/sub.
  - `overflow = |q[N-1:WIDTH]`.
  - `out_remainder` = final remainder, WIDTH bits.
  - `div_by_zero = 0`.
- Divide by zero: `out_quotient` = all ones, `out_remainder = left`, `div_by_zero = 1`, `overflow = 0`.
- Operands are latched at acceptance. Changes on `left`/`right` while busy have no effect.
- `go` in RUN or DONE is ignored. No queuing: the controller must re-assert `go` in IDLE.
- Output registers change only in the DONE cycle. They hold through later IDLE/RUN cycles until the next DONE.

## Timing
- Reset value of every output: `out_quotient=0`, `out_remainder=0`, `overflow=0`, `div_by_zero=0`, `done=0`. State resets to IDLE.
- Reset may assert at any time, including mid-RUN. The operation is abandoned, with no `done` and no output update.
- Cycle numbering: `go` is high in cycle 0 and sampled at the edge ending cycle 0.
- Normal path:
  - RUN occupies cycles 1..N.
  - `done=1` and results are valid in cycle N+1.
  - IDLE from cycle N+2; the earliest next accepted `go` is in cycle N+2.
  - Throughput: one division per N+2 cycles.
- Divide-by-zero path: `done=1` in cycle 1; the next `go` is accepted in cycle 2.
- `done` is exactly one cycle wide. It is never asserted twice for one acceptance.
- A `go` held continuously high restarts in IDLE cycle N+2, which gives a new division.

## Test plan
All cases use WIDTH=8, INT=4, FRACT=4, so N=12 and `done` is in cycle 13.
- left=0x30 (3.0), right=0x20 (2.0) -> cycle 13: out_quotient=0x18 (1.5), out_remainder=0x00, overflow=0, div_by_zero=0. `done` is low in cycles 1–12 and 14.
- left=0x10 (1.0), right=0x30 (3.0) -> out_quotient=0x05 (0.3125), out_remainder=0x10, overflow=0.
- left=0xF0 (15.0), right=0x01 (0.0625) -> out_quotient=0x00, overflow=1, out_remainder=0x00.
- left=0x30, right=0x00 -> cycle 1: done=1, out_quotient=0xFF, out_remainder=0x30, div_by_zero=1, overflow=0.
- Start 0x30/0x20, then change left/right to 0xFF/0x01 and pulse `go` in cycle 5 -> cycle 13 result still 0x18; the extra `go` is ignored.
- Start 0x30/0x20, assert reset in cycle 6 -> all outputs 0 immediately, no `done`. After release, 0x10/0x30 -> 0x05 exactly 13 cycles after its `go`. Also run a randomized scoreboard of ≥1000 pairs against `(left<<4)/right`.

Source files
------------

// File: rtl/fixed_p_std_div_pipe.sv
// Unsigned fixed-point divider: (left << FRACT_WIDTH) / right by restoring
// long division, one quotient bit per cycle, go/done handshake.
// Ports: clk, reset (async, active-low), go, left, right -> out_quotient,
//   out_remainder, overflow, div_by_zero, done (one-cycle result pulse).
module fixed_p_std_div_pipe #(
   parameter int WIDTH       = 32,
   parameter int INT_WIDTH   = 8,
   parameter int FRACT_WIDTH = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             go,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   output logic [WIDTH-1:0] out_quotient,
   output logic [WIDTH-1:0] out_remainder,
   output logic             overflow,
   output logic             div_by_zero,
   output logic             done
);

   localparam int N  = WIDTH + FRACT_WIDTH;
   localparam int CW = $clog2(N + 1);

   if (INT_WIDTH + FRACT_WIDTH != WIDTH) begin : g_bad_format
      $error("INT_WIDTH + FRACT_WIDTH must equal WIDTH");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   logic [N-1:0]     dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH:0]   rem;
   logic [N-1:0]     quo;
   logic [CW-1:0]    cnt;

   logic accept;
   logic start_dz;
   logic step;
   logic last;

   logic [WIDTH+1:0] wide;
   logic [WIDTH+1:0] diff;
   logic             q_bit;
   logic [WIDTH:0]   rem_next;
   logic [N:0]       quo_full;

   // One extra headroom bit on the trial subtraction so its sign bit is
   // the borrow: a clear sign means remainder >= divisor.
   assign wide     = {rem, dividend[N-1]};
   assign diff     = wide - {2'b00, divisor};
   assign q_bit    = ~diff[WIDTH+1];
   assign rem_next = q_bit ? diff[WIDTH:0] : wide[WIDTH:0];
   assign quo_full = {quo, q_bit};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      start_dz   = 1'b0;
      step       = 1'b0;
      last       = 1'b0;
      unique case (state)
         IDLE: begin
            if (go) begin
               if (right != '0) begin
                  accept     = 1'b1;
                  state_next = RUN;
               end else begin
                  start_dz   = 1'b1;
                  state_next = DONE;
               end
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CW'(N - 1)) begin
               last       = 1'b1;
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dividend <= '0;
         divisor  <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
      end else if (accept) begin
         dividend <= {left, {FRACT_WIDTH{1'b0}}};
         divisor  <= right;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
      end else if (step) begin
         dividend <= {dividend[N-2:0], 1'b0};
         rem      <= rem_next;
         quo      <= quo_full[N-1:0];
         cnt      <= cnt + CW'(1);
      end
   end

   // Results are registered on the edge that enters DONE, so they are
   // visible in the same cycle as the done pulse and hold until the next.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_quotient  <= '0;
         out_remainder <= '0;
         overflow      <= 1'b0;
         div_by_zero   <= 1'b0;
         done          <= 1'b0;
      end else begin
         done <= last | start_dz;
         if (last) begin
            out_quotient  <= quo_full[WIDTH-1:0];
            out_remainder <= rem_next[WIDTH-1:0];
            // Bit N of quo_full is always zero here; folding it in is harmless.
            overflow      <= |quo_full[N:WIDTH];
            div_by_zero   <= 1'b0;
         end else if (start_dz) begin
            out_quotient  <= '1;
            out_remainder <= left;
            overflow      <= 1'b0;
            div_by_zero   <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fixed_p_std_div_pipe.sv
// Self-checking bench for fixed_p_std_div_pipe at WIDTH=8, INT=4, FRACT=4.
// Scoreboard of expected results, one task per scenario.
module tb_fixed_p_std_div_pipe;

   localparam int W = 8;
   localparam int N = 12;

   logic         clk = 1'b0;
   logic         reset;
   logic         go;
   logic [W-1:0] left;
   logic [W-1:0] right;
   logic [W-1:0] out_quotient;
   logic [W-1:0] out_remainder;
   logic         overflow;
   logic         div_by_zero;
   logic         done;

   typedef logic [17:0] res_t;

   res_t exp_q[$];
   res_t got;
   res_t exp_r;
   int   tests_run = 0;
   int   tests_failed = 0;

   assign got = {out_quotient, out_remainder, overflow, div_by_zero};

   always #5 clk = ~clk;

   fixed_p_std_div_pipe #(
      .WIDTH(8),
      .INT_WIDTH(4),
      .FRACT_WIDTH(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .go(go),
      .left(left),
      .right(right),
      .out_quotient(out_quotient),
      .out_remainder(out_remainder),
      .overflow(overflow),
      .div_by_zero(div_by_zero),
      .done(done)
   );

   function automatic res_t model(input logic [7:0] l, input logic [7:0] r);
      logic [11:0] num;
      logic [11:0] qf;
      logic [7:0]  rm;
      if (r == 8'h00) return {8'hFF, l, 1'b0, 1'b1};
      num = {l, 4'h0};
      qf  = num / {4'h0, r};
      rm  = 8'(num % {4'h0, r});
      return {qf[7:0], rm, |qf[11:8], 1'b0};
   endfunction

   // Drive go for one cycle from a negedge; returns at the negedge of cycle 1.
   task automatic start_op(input logic [7:0] l, input logic [7:0] r);
      left  = l;
      right = r;
      go    = 1'b1;
      exp_q.push_back(model(l, r));
      @(negedge clk);
      go = 1'b0;
   endtask

   // Returns the cycle number at which done is seen, or -1 on timeout.
   task automatic wait_done(input int start, output int lat);
      lat = start;
      while (done !== 1'b1 && lat < start + 40) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      go    = 1'b0;
      left  = '0;
      right = '0;
      repeat (2) @(negedge clk);
      tests_run++;
      if (got !== 18'h0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got %h expected %h", got, 18'h0);
      end
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_done: got %b expected 0", done);
      end
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] tl[3] = '{8'h30, 8'h10, 8'hF0};
      logic [7:0] tr[3] = '{8'h20, 8'h30, 8'h01};
      res_t       tx[3] = '{{8'h18, 8'h00, 1'b0, 1'b0},
                            {8'h05, 8'h10, 1'b0, 1'b0},
                            {8'h00, 8'h00, 1'b1, 1'b0}};
      int lat;
      for (int i = 0; i < 3; i++) begin
         start_op(tl[i], tr[i]);
         wait_done(1, lat);
         exp_r = exp_q.pop_front();
         tests_run++;
         if (lat !== 13) begin
            tests_failed++;
            $display("FAIL basic_latency[%0d]: got %0d expected 13", i, lat);
         end
         tests_run++;
         if (got !== exp_r || got !== tx[i]) begin
            tests_failed++;
            $display("FAIL basic_result[%0d]: got %h expected %h", i, got, tx[i]);
         end
         @(negedge clk);
         tests_run++;
         if (done !== 1'b0 || got !== tx[i]) begin
            tests_failed++;
            $display("FAIL basic_after[%0d]: done %b res %h expected 0 %h",
                     i, done, got, tx[i]);
         end
      end
   endtask

   task automatic test_div_zero();
      int lat;
      start_op(8'h30, 8'h00);
      wait_done(1, lat);
      exp_r = exp_q.pop_front();
      tests_run++;
      if (lat !== 1) begin
         tests_failed++;
         $display("FAIL dz_latency: got %0d expected 1", lat);
      end
      tests_run++;
      if (got !== exp_r) begin
         tests_failed++;
         $display("FAIL dz_result: got %h expected %h", got, exp_r);
      end
      @(negedge clk);
      tests_run++;
      if (done !== 1'b0) begin
         tests_failed++;
         $display("FAIL dz_pulse_width: got %b expected 0", done);
      end
      // Cycle 2: next go must be accepted right away.
      start_op(8'h10, 8'h30);
      wait_done(1, lat);
      exp_r = exp_q.pop_front();
      tests_run++;
      if (lat !== 13 || got !== exp_r) begin
         tests_failed++;
         $display("FAIL dz_next: lat %0d res %h expected 13 %h", lat, got, exp_r);
      end
      @(negedge clk);
   endtask

   task automatic test_ignore_busy();
      int lat;
      int extra;
      start_op(8'h30, 8'h20);
      repeat (4) @(negedge clk);
      left  = 8'hFF;
      right = 8'h01;
      go    = 1'b1;
      @(negedge clk);
      go = 1'b0;
      wait_done(6, lat);
      exp_r = exp_q.pop_front();
      tests_run++;
      if (lat !== 13 || got !== exp_r) begin
         tests_failed++;
         $display("FAIL busy_result: lat %0d res %h expected 13 %h", lat, got, exp_r);
      end
      extra = 0;
      for (int c = 0; c < N + 6; c++) begin
         @(negedge clk);
         if (done === 1'b1) extra++;
      end
      tests_run++;
      if (extra !== 0) begin
         tests_failed++;
         $display("FAIL busy_no_queue: got %0d dones expected 0", extra);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int stray;
      start_op(8'h30, 8'h20);
      repeat (5) @(negedge clk);
      reset = 1'b0;
      #1;
      void'(exp_q.pop_front());
      tests_run++;
      if (got !== 18'h0 || done !== 1'b0) begin
         tests_failed++;
         $display("FAIL midrun_reset: res %h done %b expected 0 0", got, done);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      stray = 0;
      for (int c = 0; c < N + 4; c++) begin
         @(negedge clk);
         if (done === 1'b1) stray++;
      end
      tests_run++;
      if (stray !== 0 || got !== 18'h0) begin
         tests_failed++;
         $display("FAIL midrun_abandon: dones %0d res %h expected 0 0", stray, got);
      end
      start_op(8'h10, 8'h30);
      wait_done(1, lat);
      exp_r = exp_q.pop_front();
      tests_run++;
      if (lat !== 13 || got !== exp_r) begin
         tests_failed++;
         $display("FAIL midrun_restart: lat %0d res %h expected 13 %h", lat, got, exp_r);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [7:0] bl[3] = '{8'h30, 8'h10, 8'h7F};
      logic [7:0] br[3] = '{8'h20, 8'h30, 8'h05};
      int k;
      k     = 0;
      left  = bl[0];
      right = br[0];
      go    = 1'b1;
      exp_q.push_back(model(bl[0], br[0]));
      @(negedge clk);
      for (int c = 1; c <= 45; c++) begin
         if (done === 1'b1) begin
            exp_r = exp_q.pop_front();
            tests_run++;
            if (c !== 13 + 14 * k || got !== exp_r) begin
               tests_failed++;
               $display("FAIL b2b[%0d]: cycle %0d res %h expected %0d %h",
                        k, c, got, 13 + 14 * k, exp_r);
            end
            k++;
            if (k < 3) begin
               left  = bl[k];
               right = br[k];
               exp_q.push_back(model(bl[k], br[k]));
            end
         end
         if (c == 41) go = 1'b0;
         @(negedge clk);
      end
      tests_run++;
      if (k !== 3) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d expected 3", k);
      end
      exp_q.delete();
   endtask

   task automatic test_random();
      int lat;
      int want;
      logic [7:0] l;
      logic [7:0] r;
      for (int i = 0; i < 1000; i++) begin
         l = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) r = 8'h00;
         else r = 8'($urandom_range(1, 255));
         want = (r == 8'h00) ? 1 : 13;
         start_op(l, r);
         wait_done(1, lat);
         exp_r = exp_q.pop_front();
         tests_run++;
         if (lat !== want || got !== exp_r) begin
            tests_failed++;
            $display("FAIL rand[%0d] %h/%h: lat %0d res %h expected %0d %h",
                     i, l, r, lat, got, want, exp_r);
         end
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_div_zero();
      test_ignore_busy();
      test_reset_mid_run();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
